// File: rtl/mem_cache_pkg.sv
// Shared types and address-mapping helpers for the MEM-stage 2-way data cache.
package mem_cache_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2
  } state_e;

  // Widest line the word selector accepts (64 words of 32 bits).
  localparam int LINE_MAX_BITS = 2048;

  function automatic int off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int line_words, input int sets);
    return 30 - off_w(line_words) - idx_w(sets);
  endfunction

  function automatic logic [31:0] word_sel(input logic [LINE_MAX_BITS-1:0] line, input int word);
    return line[word*32 +: 32];
  endfunction

endpackage

// File: rtl/cache_way_array.sv
// One cache way: per-set valid bit, tag and line data with a combinational
// lookup port, a whole-line fill port and a single-word update port.
module cache_way_array
  import mem_cache_pkg::*;
#(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 2,
  localparam int OFF_W     = off_w(LINE_WORDS),
  localparam int IDX_W     = idx_w(SETS),
  localparam int TAG_W     = tag_w(LINE_WORDS, SETS),
  localparam int LINE_BITS = LINE_WORDS * 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inv_all,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic                 rd_valid,
  output logic [TAG_W-1:0]     rd_tag,
  output logic [LINE_BITS-1:0] rd_line,
  input  logic                 fill_en,
  input  logic [IDX_W-1:0]     fill_idx,
  input  logic [TAG_W-1:0]     fill_tag,
  input  logic [LINE_BITS-1:0] fill_line,
  input  logic                 upd_en,
  input  logic [IDX_W-1:0]     upd_idx,
  input  logic [OFF_W-1:0]     upd_word,
  input  logic [31:0]          upd_data
);

  logic [SETS-1:0]      valid_q;
  logic [TAG_W-1:0]     tag_q  [SETS];
  logic [LINE_BITS-1:0] data_q [SETS];

  // Invalidate beats fill, so a line filled in a flush cycle stays invalid.
  always_ff @(posedge clk) begin
    if (rst || inv_all) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= fill_line;
    end else if (upd_en) begin
      data_q[upd_idx][int'(upd_word)*32 +: 32] <= upd_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_line  = data_q[rd_idx];

endmodule

// File: rtl/mem_cache_ctrl.sv
// 2-way set-associative write-through / no-write-allocate data cache controller
// between the MEM stage and the SRAM controller; drives the pipeline pause.
//
// state   | meaning
// IDLE    | serve load hits in-cycle, launch fills and write-throughs
// RD_MISS | line fill outstanding; forward the word on mem_ready
// WR_THRU | word write-through outstanding; patch a hit line on mem_ready
module mem_cache_ctrl
  import mem_cache_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE  = 32'd1024,
  parameter int          SETS       = 64,
  parameter int          LINE_WORDS = 2,
  parameter int          STAT_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_rd_en,
  input  logic                     cpu_wr_en,
  input  logic [31:0]              cpu_addr,
  input  logic [31:0]              cpu_wdata,
  output logic [31:0]              cpu_rdata,
  output logic                     pause,
  input  logic                     flush,
  output logic                     mem_rd_req,
  output logic                     mem_wr_req,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic [LINE_WORDS*32-1:0] mem_rdata,
  input  logic                     mem_ready,
  output logic [STAT_W-1:0]        hit_cnt,
  output logic [STAT_W-1:0]        miss_cnt
);

  localparam int OFF_W     = off_w(LINE_WORDS);
  localparam int IDX_W     = idx_w(SETS);
  localparam int TAG_W     = tag_w(LINE_WORDS, SETS);
  localparam int LINE_BITS = LINE_WORDS * 32;

  logic [31:0]      a;
  logic [OFF_W-1:0] a_word;
  logic [IDX_W-1:0] a_idx;
  logic [TAG_W-1:0] a_tag;

  assign a      = cpu_addr - ADDR_BASE;
  assign a_word = a[OFF_W+1:2];
  assign a_idx  = a[OFF_W+IDX_W+1:OFF_W+2];
  assign a_tag  = a[31:OFF_W+IDX_W+2];

  state_e              state_q, state_d;
  logic [SETS-1:0]     lru_q, lru_d;
  logic [STAT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic [STAT_W-1:0]   miss_cnt_q, miss_cnt_d;
  logic                rd_req_q, rd_req_d;
  logic                wr_req_q, wr_req_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [OFF_W-1:0]    word_q, word_d;

  // Outside IDLE the lookup follows the latched request, not the frozen pipeline.
  logic [IDX_W-1:0]     look_idx;
  logic [TAG_W-1:0]     look_tag;
  logic [1:0]           way_valid;
  logic [TAG_W-1:0]     way_tag  [2];
  logic [LINE_BITS-1:0] way_line [2];
  logic [1:0]           fill_en;
  logic [1:0]           upd_en;

  assign look_idx = (state_q == IDLE) ? a_idx : idx_q;
  assign look_tag = (state_q == IDLE) ? a_tag : tag_q;

  for (genvar w = 0; w < 2; w++) begin : g_way
    cache_way_array #(
      .SETS       (SETS),
      .LINE_WORDS (LINE_WORDS)
    ) u_way (
      .clk       (clk),
      .rst       (rst),
      .inv_all   (flush),
      .rd_idx    (look_idx),
      .rd_valid  (way_valid[w]),
      .rd_tag    (way_tag[w]),
      .rd_line   (way_line[w]),
      .fill_en   (fill_en[w]),
      .fill_idx  (idx_q),
      .fill_tag  (tag_q),
      .fill_line (mem_rdata),
      .upd_en    (upd_en[w]),
      .upd_idx   (idx_q),
      .upd_word  (word_q),
      .upd_data  (wdata_q)
    );
  end

  logic hit0, hit1, hit, hit_way, victim;

  assign hit0    = way_valid[0] && (way_tag[0] == look_tag);
  assign hit1    = way_valid[1] && (way_tag[1] == look_tag);
  assign hit     = hit0 || hit1;
  assign hit_way = !hit0;
  assign victim  = !way_valid[0] ? 1'b0 :
                   !way_valid[1] ? 1'b1 : lru_q[idx_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lru_q      <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      rd_req_q   <= 1'b0;
      wr_req_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      idx_q      <= '0;
      tag_q      <= '0;
      word_q     <= '0;
    end else begin
      lru_q      <= lru_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      rd_req_q   <= rd_req_d;
      wr_req_q   <= wr_req_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      idx_q      <= idx_d;
      tag_q      <= tag_d;
      word_q     <= word_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lru_d      = lru_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    rd_req_d   = rd_req_q;
    wr_req_d   = wr_req_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    idx_d      = idx_q;
    tag_d      = tag_q;
    word_d     = word_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_wr_en) begin
          wr_req_d = 1'b1;
          addr_d   = a;
          wdata_d  = cpu_wdata;
          idx_d    = a_idx;
          tag_d    = a_tag;
          word_d   = a_word;
          state_d  = WR_THRU;
        end else if (cpu_rd_en) begin
          if (hit) begin
            lru_d[a_idx] = ~hit_way;
            if (hit_cnt_q != {STAT_W{1'b1}}) hit_cnt_d = hit_cnt_q + 1'b1;
          end else begin
            if (miss_cnt_q != {STAT_W{1'b1}}) miss_cnt_d = miss_cnt_q + 1'b1;
            rd_req_d = 1'b1;
            addr_d   = {a[31:OFF_W+2], {(OFF_W+2){1'b0}}};
            idx_d    = a_idx;
            tag_d    = a_tag;
            word_d   = a_word;
            state_d  = RD_MISS;
          end
        end
      end
      RD_MISS: begin
        if (mem_ready) begin
          lru_d[idx_q] = ~victim;
          rd_req_d     = 1'b0;
          state_d      = IDLE;
        end
      end
      WR_THRU: begin
        if (mem_ready) begin
          if (hit) lru_d[idx_q] = ~hit_way;
          wr_req_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pause     = 1'b0;
    cpu_rdata = '0;
    fill_en   = '0;
    upd_en    = '0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (cpu_wr_en) begin
            pause = 1'b1;
          end else if (cpu_rd_en) begin
            pause     = !hit;
            cpu_rdata = word_sel(LINE_MAX_BITS'(way_line[hit_way]), int'(a_word));
          end
        end
        RD_MISS: begin
          pause     = !mem_ready;
          cpu_rdata = word_sel(LINE_MAX_BITS'(mem_rdata), int'(word_q));
          if (mem_ready && !flush) fill_en[victim] = 1'b1;
        end
        WR_THRU: begin
          pause = !mem_ready;
          if (mem_ready && hit) upd_en[hit_way] = 1'b1;
        end
        default: pause = 1'b0;
      endcase
    end
  end

  assign mem_rd_req = rd_req_q;
  assign mem_wr_req = wr_req_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign hit_cnt    = hit_cnt_q;
  assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_mem_cache_ctrl.sv
// Bench for mem_cache_ctrl: a vector table of loads/stores with hand-derived
// hit/miss and request addresses, backed by an SRAM model and a read-data scoreboard.
module tb_mem_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_rd_en, cpu_wr_en;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        pause, flush;
  logic        mem_rd_req, mem_wr_req;
  logic [31:0] mem_addr, mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_ready;
  logic [15:0] hit_cnt, miss_cnt;

  always #5 clk = ~clk;

  mem_cache_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_rd_en  (cpu_rd_en),
    .cpu_wr_en  (cpu_wr_en),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .pause      (pause),
    .flush      (flush),
    .mem_rd_req (mem_rd_req),
    .mem_wr_req (mem_wr_req),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
  );

  typedef enum logic [1:0] {OP_LD, OP_ST, OP_BOTH} op_e;
  typedef struct {
    op_e         op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_miss;
    logic [31:0] exp_mem_addr;
    int          ready_dly;
    logic        flush_drv;
    logic        flush_rdy;
  } vec_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          exp_hits = 0;
  int          exp_misses = 0;
  logic [31:0] sb_q [$];
  logic [31:0] sram [logic [31:0]];
  vec_t        vecs [21];

  function automatic vec_t mk(op_e op, logic [31:0] addr, logic [31:0] wdata, logic miss,
                              logic [31:0] maddr, int dly, logic fd, logic fr);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wdata; v.exp_miss = miss;
    v.exp_mem_addr = maddr; v.ready_dly = dly; v.flush_drv = fd; v.flush_rdy = fr;
    return v;
  endfunction

  function automatic logic [31:0] sram_rd(logic [31:0] a);
    if (sram.exists(a)) return sram[a];
    return 32'hC0DE_0000 ^ a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic pop_check(input string name);
    logic [31:0] e;
    if (sb_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: scoreboard empty, got %h", name, cpu_rdata);
    end else begin
      e = sb_q.pop_front();
      chk(name, cpu_rdata, e);
    end
  endtask

  task automatic idle_inputs();
    cpu_rd_en = 1'b0;
    cpu_wr_en = 1'b0;
    flush     = 1'b0;
    mem_ready = 1'b0;
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_hit_cnt"},  32'(hit_cnt),  32'(exp_hits));
    chk({tag, "_miss_cnt"}, 32'(miss_cnt), 32'(exp_misses));
  endtask

  task automatic run_vec(input vec_t v, input int n);
    logic [31:0] a;
    logic [31:0] line;
    string       t;
    t    = $sformatf("v%0d", n);
    a    = v.addr - 32'd1024;
    line = a & ~32'd7;
    @(negedge clk);
    cpu_addr  = v.addr;
    cpu_wdata = v.wdata;
    cpu_rd_en = (v.op != OP_ST);
    cpu_wr_en = (v.op != OP_LD);
    flush     = v.flush_drv;
    if (v.op == OP_LD) sb_q.push_back(sram_rd(a));
    #1;
    if (v.op == OP_LD && !v.exp_miss) begin
      chk({t, "_hit_pause"}, 32'(pause), 32'd0);
      pop_check({t, "_hit_rdata"});
      @(negedge clk);
      idle_inputs();
      exp_hits++;
      #1 chk({t, "_hit_noreq"}, 32'({mem_rd_req, mem_wr_req}), 32'd0);
    end else begin
      chk({t, "_req_pause"}, 32'(pause), 32'd1);
      @(negedge clk);
      flush = 1'b0;
      #1;
      if (v.op == OP_LD) begin
        chk({t, "_rd_req"}, 32'({mem_rd_req, mem_wr_req}), 32'b10);
      end else begin
        chk({t, "_wr_req"}, 32'({mem_rd_req, mem_wr_req}), 32'b01);
        chk({t, "_wdata"}, mem_wdata, v.wdata);
      end
      chk({t, "_mem_addr"}, mem_addr, v.exp_mem_addr);
      for (int k = 0; k < v.ready_dly; k++) begin
        chk({t, "_stall_pause"}, 32'(pause), 32'd1);
        @(negedge clk);
      end
      mem_rdata = {sram_rd(line + 32'd4), sram_rd(line)};
      mem_ready = 1'b1;
      flush     = v.flush_rdy;
      #1;
      chk({t, "_done_pause"}, 32'(pause), 32'd0);
      chk({t, "_held_addr"}, mem_addr, v.exp_mem_addr);
      if (v.op == OP_LD) begin
        pop_check({t, "_fill_rdata"});
        exp_misses++;
      end else begin
        sram[a] = v.wdata;
      end
      @(negedge clk);
      idle_inputs();
      #1 chk({t, "_req_drop"}, 32'({mem_rd_req, mem_wr_req}), 32'd0);
    end
    chk_counters(t);
  endtask

  initial begin
    sram[32'd0] = 32'hAAAA_AAAA;
    sram[32'd4] = 32'hBBBB_BBBB;

    vecs[0]  = mk(OP_LD,   32'd1024, 32'd0,        1'b1, 32'd0,         5, 1'b0, 1'b0);
    vecs[1]  = mk(OP_LD,   32'd1028, 32'd0,        1'b0, 32'd0,         0, 1'b0, 1'b0);
    vecs[2]  = mk(OP_ST,   32'd1028, 32'h1234,     1'b1, 32'd4,         3, 1'b0, 1'b0);
    vecs[3]  = mk(OP_LD,   32'd1028, 32'd0,        1'b0, 32'd0,         0, 1'b0, 1'b0);
    vecs[4]  = mk(OP_LD,   32'd1024, 32'd0,        1'b0, 32'd0,         0, 1'b0, 1'b0);
    vecs[5]  = mk(OP_LD,   32'd1536, 32'd0,        1'b1, 32'd512,       2, 1'b0, 1'b0);
    vecs[6]  = mk(OP_LD,   32'd1024, 32'd0,        1'b0, 32'd0,         0, 1'b0, 1'b0);
    vecs[7]  = mk(OP_LD,   32'd2048, 32'd0,        1'b1, 32'd1024,      1, 1'b0, 1'b0);
    vecs[8]  = mk(OP_LD,   32'd1024, 32'd0,        1'b0, 32'd0,         0, 1'b0, 1'b0);
    vecs[9]  = mk(OP_LD,   32'd1536, 32'd0,        1'b1, 32'd512,       0, 1'b0, 1'b0);
    vecs[10] = mk(OP_ST,   32'd3000, 32'hDEADBEEF, 1'b1, 32'd1976,      2, 1'b0, 1'b0);
    vecs[11] = mk(OP_LD,   32'd3000, 32'd0,        1'b1, 32'd1976,      1, 1'b0, 1'b0);
    vecs[12] = mk(OP_LD,   32'd3004, 32'd0,        1'b0, 32'd0,         0, 1'b0, 1'b0);
    vecs[13] = mk(OP_LD,   32'd1020, 32'd0,        1'b1, 32'hFFFF_FFF8, 1, 1'b0, 1'b0);
    vecs[14] = mk(OP_LD,   32'd1020, 32'd0,        1'b0, 32'd0,         0, 1'b0, 1'b0);
    vecs[15] = mk(OP_BOTH, 32'd1024, 32'h5555,     1'b1, 32'd0,         1, 1'b0, 1'b0);
    vecs[16] = mk(OP_LD,   32'd1024, 32'd0,        1'b0, 32'd0,         0, 1'b0, 1'b0);
    vecs[17] = mk(OP_LD,   32'd1024, 32'd0,        1'b0, 32'd0,         0, 1'b1, 1'b0);
    vecs[18] = mk(OP_LD,   32'd1024, 32'd0,        1'b1, 32'd0,         2, 1'b0, 1'b1);
    vecs[19] = mk(OP_LD,   32'd1024, 32'd0,        1'b1, 32'd0,         1, 1'b0, 1'b0);
    vecs[20] = mk(OP_LD,   32'd1028, 32'd0,        1'b0, 32'd0,         0, 1'b0, 1'b0);

    rst       = 1'b1;
    cpu_addr  = 32'd1024;
    cpu_wdata = 32'd0;
    mem_rdata = 64'd0;
    idle_inputs();
    cpu_rd_en = 1'b1;
    @(negedge clk);
    #1 chk("rst_pause_forced", 32'(pause), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cpu_rd_en = 1'b0;
    #1;
    chk("rst_reqs", 32'({mem_rd_req, mem_wr_req}), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk_counters("rst");

    for (int i = 0; i < 21; i++) run_vec(vecs[i], i);

    // Back-to-back hits on consecutive cycles.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cpu_rd_en = 1'b1;
      cpu_addr  = (i % 2 == 0) ? 32'd1024 : 32'd1028;
      sb_q.push_back(sram_rd(cpu_addr - 32'd1024));
      #1;
      chk("b2b_pause", 32'(pause), 32'd0);
      pop_check("b2b_rdata");
    end
    @(negedge clk);
    idle_inputs();
    exp_hits += 4;
    #1 chk_counters("b2b");

    // Reset while a line fill is outstanding.
    @(negedge clk);
    cpu_rd_en = 1'b1;
    cpu_addr  = 32'd1536;
    #1 chk("rstmid_miss_pause", 32'(pause), 32'd1);
    @(negedge clk);
    #1 chk("rstmid_rd_req", 32'(mem_rd_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("rstmid_pause_forced", 32'(pause), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cpu_rd_en = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
    #1;
    chk("rstmid_rd_req_drop", 32'(mem_rd_req), 32'd0);
    chk("rstmid_pause", 32'(pause), 32'd0);
    chk_counters("rstmid");
    @(negedge clk);
    mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    #1 chk("late_ready_noreq", 32'({mem_rd_req, mem_wr_req}), 32'd0);
    run_vec(mk(OP_LD, 32'd1024, 32'd0, 1'b1, 32'd0, 1, 1'b0, 1'b0), 100);
    run_vec(mk(OP_LD, 32'd1536, 32'd0, 1'b1, 32'd512, 0, 1'b0, 1'b0), 101);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
